fetch_unit: RTL
===============

# fetch_unit

Instruction-fetch stage owning the architectural PC register, the instruction-memory request handshake and the IF/ID holding register. It presents `if_pc` and `if_instr` to the next-PC logic and the decoder, then loads the resulting next PC once decode accepts the instruction. Fetch is non-speculative: one instruction is in flight at a time, with no prediction. A fetched HLT freezes the stage until reset.

## Interface
- `RESET_PC`, default 16'h0000: PC value loaded on reset.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  16  fetch address; always equals the PC register.
- `imem_rdy`  in  1  memory has `imem_data` valid this cycle.
- `imem_data`  in  16  fetched instruction word.
- `if_valid`  out  1  `if_instr`/`if_pc` hold a fetched, unaccepted instruction.
- `if_instr`  out  16  latched instruction, fed to decode and next-PC logic.
- `if_pc`  out  16  address of `if_instr`, fed to next-PC logic as current PC.
- `pc_next`  in  16  next PC computed from `if_pc`, `if_instr` and flags; sampled only on accept.
- `id_stall`  in  1  decode cannot accept this cycle.
- `halted`  out  1  HLT retired; fetch frozen.
- `fetch_count`  out  16  present only with FETCH_PERF_CNT_EN.
- `wait_count`  out  16  present only with FETCH_PERF_CNT_EN.

## Operation
- **States:** IDLE, FETCH, VALID, HALTED.
- **IDLE:** reset state. `imem_req`=0. Unconditionally goes to FETCH the next cycle.
- **FETCH:** `imem_req`=1, `imem_addr`=PC.
  - On `imem_rdy`: latch `if_instr`<=`imem_data` and `if_pc`<=PC, set `if_valid`, go to VALID.
  - Without `imem_rdy`: stay in FETCH with the address held stable.
- **VALID:** `imem_req`=0, `if_valid`=1.
  - Accept occurs when `~id_stall`.
  - If `if_instr[15:12]`==4'b1111 (HLT): on accept, go to HALTED; PC is unchanged.
  - Otherwise, on accept: PC<=`{pc_next[15:1],1'b0}`, clear `if_valid`, go to FETCH.
  - While `id_stall`: hold all registers.
- **HALTED:** `imem_req`=0, `if_valid`=0, `halted`=1. Only reset exits this state.
- `imem_rdy` is ignored whenever `imem_req`=0.
- PC bit 0 is always 0. Wrap-around is `pc_next`'s responsibility; any 16-bit value is loaded as given (bit 0 cleared).

## Timing
- **Reset (async):** state=IDLE, PC=`RESET_PC`, `if_valid`=0, `if_instr`=16'h0000, `if_pc`=16'h0000, `halted`=0, `imem_req`=0, counters=0.
- **First request:** `imem_req` rises in the 2nd rising edge's cycle after `rst_n` deasserts (IDLE lasts one cycle).
- **Fetch latency:** `imem_rdy` in cycle N → `if_valid`=1 in N+1.
- **Accept:** accept in cycle M → `imem_req`=1 with `imem_addr`=`pc_next` in M+1.
- **Throughput:** zero-wait memory and no stalls give 2 cycles per instruction.
- **Reset mid-operation:** `rst_n` low during FETCH or VALID drops `imem_req` and `if_valid` asynchronously. Any outstanding memory response is discarded.
- **Simultaneous `imem_rdy` and `rst_n` low:** reset wins; nothing is latched.
- **HLT with `id_stall`=1:** stays in VALID until accepted; `halted` rises the cycle after accept.
- `imem_addr`, `if_instr` and `if_pc` are registered (glitch-free). `imem_req` and `halted` decode directly from state.

## Configuration
- **FETCH_PERF_CNT_EN defined:**
  - `fetch_count` increments on each accept, including HLT.
  - `wait_count` increments each cycle in FETCH with `imem_rdy`=0.
  - Both are 16-bit, saturate at 16'hFFFF and reset to 0.
- **FETCH_PERF_CNT_EN undefined:** the counter logic and both ports are absent. All other behaviour is identical.

## Structure
- **Package `fetch_pkg`:** state encoding (IDLE=2'b00, FETCH=2'b01, VALID=2'b10, HALTED=2'b11), `OP_HLT`=4'b1111, default `RESET_PC`.
- **Sub-module `fetch_perf_cnt`:** holds both saturating counters; instantiated only under FETCH_PERF_CNT_EN.

## Test plan
- **Zero-wait fetch:** `imem_rdy` always 1, `RESET_PC`=16'h0000, `pc_next`=`if_pc`+2 → `imem_addr` sequence 0x0000, 0x0002, 0x0004 at 2-cycle spacing. `if_pc` tracks the address.
- **Memory wait:** `imem_rdy` held 0 for 3 cycles at address 0x0010 → `imem_addr` stable at 0x0010, `if_valid` rises the cycle after `imem_rdy`, `wait_count`=3.
- **Decode stall:** `if_instr`=16'hA123, `id_stall`=1 for 4 cycles → `if_instr`/`if_pc` unchanged and `imem_req`=0 throughout. PC loads `pc_next` the cycle after the stall drops.
- **Branch redirect:** `pc_next`=16'h0041 on accept → next `imem_addr`=16'h0040.
- **Halt:** fetch 16'hF000 at 0x0006 under `id_stall` → after accept `halted`=1 and `imem_req` stays 0 for 20 cycles despite `imem_rdy` toggling. `fetch_count` includes the HLT.
- **Reset mid-fetch:** `rst_n` pulsed low while FETCH waits at 0x0020, with `imem_rdy` asserted during reset → `imem_req`=0 immediately, `if_valid`=0, restart from `RESET_PC` after IDLE.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_FETCH  = 2'b01,
    ST_VALID  = 2'b10,
    ST_HALTED = 2'b11
  } fetch_state_e;

  localparam logic [3:0]  OP_HLT           = 4'b1111;
  localparam logic [15:0] RESET_PC_DEFAULT = 16'h0000;
  localparam logic [15:0] CNT_MAX          = 16'hFFFF;

  // True when the instruction word carries the HLT opcode.
  function automatic logic is_hlt(input logic [15:0] instr);
    return (instr[15:12] == OP_HLT);
  endfunction

endpackage

// File: rtl/fetch_perf_cnt.sv
// Saturating performance counters for the fetch stage: accepted instructions
// and memory wait cycles.
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        accept_i,
  input  logic        wait_i,
  output logic [15:0] fetch_count,
  output logic [15:0] wait_count
);

  logic [15:0] fetch_cnt_q, fetch_cnt_d;
  logic [15:0] wait_cnt_q,  wait_cnt_d;

  // Next-count computation; both counters stick at all-ones.
  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    if (accept_i && (fetch_cnt_q != CNT_MAX)) fetch_cnt_d = fetch_cnt_q + 16'd1;
    if (wait_i   && (wait_cnt_q  != CNT_MAX)) wait_cnt_d  = wait_cnt_q  + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      wait_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign wait_count  = wait_cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, instruction-memory handshake and the
// IF/ID holding register. One instruction in flight, no prediction; a fetched
// HLT freezes the stage until reset.
// Optional feature macro: FETCH_PERF_CNT_EN adds fetch_count/wait_count.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [15:0] imem_data,
  output logic        if_valid,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  input  logic [15:0] pc_next,
  input  logic        id_stall,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] fetch_count,
  output logic [15:0] wait_count
`endif
);

  localparam logic [15:0] PC_ALIGN_MASK = 16'hFFFE;

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  if_instr_q, if_instr_d;
  logic [15:0]  if_pc_q, if_pc_d;
  logic         if_valid_q, if_valid_d;
  logic         accept;

  assign accept = (state_q == ST_VALID) && !id_stall;

  // Next-state and datapath update; everything holds by default.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    if_valid_d = if_valid_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_rdy) begin
          if_instr_d = imem_data;
          if_pc_d    = pc_q;
          if_valid_d = 1'b1;
          state_d    = ST_VALID;
        end
      end
      ST_VALID: begin
        if (accept) begin
          if_valid_d = 1'b0;
          if (is_hlt(if_instr_q)) begin
            state_d = ST_HALTED;
          end else begin
            pc_d    = pc_next & PC_ALIGN_MASK;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALTED: state_d = ST_HALTED;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC & PC_ALIGN_MASK;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      if_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
      if_valid_q <= if_valid_d;
    end
  end

  assign imem_req  = (state_q == ST_FETCH);
  assign halted    = (state_q == ST_HALTED);
  assign imem_addr = pc_q;
  assign if_instr  = if_instr_q;
  assign if_pc     = if_pc_q;
  assign if_valid  = if_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic fetch_wait;
  assign fetch_wait = (state_q == ST_FETCH) && !imem_rdy;

  fetch_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .accept_i    (accept),
    .wait_i      (fetch_wait),
    .fetch_count (fetch_count),
    .wait_count  (wait_count)
  );
`endif

endmodule
